// File: rtl/tdm_demux4.sv
// Receive-side TDM demultiplexer: hunts for frame sync, deinterleaves four
// WIDTH-bit slots from a serial line and presents them once per frame.
module tdm_demux4 #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]       slot_cnt_q, slot_cnt_d;
    logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
    logic [WIDTH-1:0] sr_q [4];
    logic [WIDTH-1:0] sr_d [4];
    logic [WIDTH-1:0] ch_q [4];
    logic [WIDTH-1:0] ch_d [4];
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    logic             locked_q, locked_d;

    logic             at_expected;
    logic [MW-1:0]    miss_inc;
    logic             restart;
    logic             advance;
    logic [BW-1:0]    cur_bit;
    logic [1:0]       cur_slot;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
        return (v << 1) | WIDTH'(b);
    endfunction

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        slot_cnt_d    = slot_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        sr_d          = sr_q;
        ch_d          = ch_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        restart       = 1'b0;
        advance       = 1'b0;
        at_expected   = (bit_cnt_q == '0) && (slot_cnt_q == 2'd0);
        miss_inc      = miss_cnt_q + 1'b1;

        if (en) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        restart = 1'b1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && !at_expected) begin
                        restart    = 1'b1;
                        sync_err_d = 1'b1;
                    end else if (at_expected && !frame_sync) begin
                        if (miss_inc == MW'(MISS_LIMIT)) begin
                            sync_err_d = 1'b1;
                            state_d    = HUNT;
                            bit_cnt_d  = '0;
                            slot_cnt_d = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                            advance    = 1'b1;
                        end
                    end else begin
                        if (at_expected) miss_cnt_d = '0;
                        advance = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // A (re)alignment is an ordinary bit taken at slot 0, bit 0.
        cur_bit  = restart ? '0 : bit_cnt_q;
        cur_slot = restart ? 2'd0 : slot_cnt_q;
        if (restart) miss_cnt_d = '0;

        if (restart || advance) begin
            sr_d[cur_slot] = shift_in(sr_q[cur_slot], din);
            if (cur_bit == BW'(WIDTH - 1)) begin
                bit_cnt_d  = '0;
                slot_cnt_d = cur_slot + 2'd1;
                if (cur_slot == 2'd3) begin
                    ch_d[0]       = sr_q[0];
                    ch_d[1]       = sr_q[1];
                    ch_d[2]       = sr_q[2];
                    ch_d[3]       = shift_in(sr_q[3], din);
                    frame_valid_d = 1'b1;
                end
            end else begin
                bit_cnt_d  = cur_bit + 1'b1;
                slot_cnt_d = cur_slot;
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            bit_cnt_q     <= '0;
            slot_cnt_q    <= '0;
            miss_cnt_q    <= '0;
            sr_q          <= '{default: '0};
            ch_q          <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            sr_q          <= sr_d;
            ch_q          <= ch_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a frame-position reference model queues
// the expected outputs for every clock; a monitor compares them.
module tb_tdm_demux4;

    localparam int unsigned W  = 4;
    localparam int unsigned ML = 2;
    localparam int unsigned N  = 4 * W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         din = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         frame_valid, locked, sync_err;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .frame_sync(frame_sync),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    typedef struct packed {
        logic         fv;
        logic         se;
        logic         lk;
        logic [N-1:0] ch;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position within the frame as a single bit index.
    bit           m_locked = 1'b0;
    int           m_pos = 0;
    int           m_miss = 0;
    logic [N-1:0] m_bits = '0;
    logic [N-1:0] m_ch = '0;

    task automatic model(input logic b, input logic fs, output logic fv, output logic se);
        fv = 1'b0;
        se = 1'b0;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                m_miss = 0;
                m_bits = '0;
                m_bits[N-1] = b;
                m_pos = 1;
            end
        end else if (fs && m_pos != 0) begin
            se = 1'b1;
            m_miss = 0;
            m_bits = '0;
            m_bits[N-1] = b;
            m_pos = 1;
        end else begin
            if (m_pos == 0 && !fs) m_miss++;
            else if (m_pos == 0) m_miss = 0;
            if (m_miss == ML) begin
                se = 1'b1;
                m_locked = 1'b0;
                m_miss = 0;
                m_pos = 0;
            end else begin
                m_bits[N-1-m_pos] = b;
                m_pos++;
                if (m_pos == N) begin
                    fv = 1'b1;
                    m_ch = m_bits;
                    m_pos = 0;
                end
            end
        end
    endtask

    task automatic step(input logic e_en, input logic b, input logic fs);
        exp_t x;
        logic fv, se;
        @(negedge clk);
        en = e_en;
        din = b;
        frame_sync = fs;
        fv = 1'b0;
        se = 1'b0;
        if (e_en) model(b, fs, fv, se);
        x.fv = fv;
        x.se = se;
        x.lk = m_locked;
        x.ch = m_ch;
        sb.push_back(x);
    endtask

    // gap: 0 = continuous, 1 = en alternates 1,0, 2 = random idle gaps
    task automatic send_frame(input logic [N-1:0] f, input bit sync, input int gap);
        for (int i = 0; i < N; i++) begin
            if (gap == 2) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) step(1'b0, 1'($urandom), 1'($urandom));
            end
            step(1'b1, f[N-1-i], sync && (i == 0));
            if (gap == 1) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        logic [N+2:0] act;
        @(negedge clk);
        en = 1'b0;
        frame_sync = 1'b0;
        rst_n = 1'b0;
        m_locked = 1'b0;
        m_pos = 0;
        m_miss = 0;
        m_ch = '0;
        #1;
        act = {frame_valid, sync_err, locked, ch0, ch1, ch2, ch3};
        n_cmp++;
        if (act !== '0) begin
            n_bad++;
            $display("FAIL async_reset: outputs=%h required=0", act);
        end
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {frame_valid, sync_err, locked, ch0, ch1, ch2, ch3};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle@%0t: fv=%b se=%b lk=%b ch=%h required fv=%b se=%b lk=%b ch=%h",
                             $time, a.fv, a.se, a.lk, a.ch, e.fv, e.se, e.lk, e.ch);
                end
            end
        end
    end

    initial begin : stim
        int r;
        do_reset(3);

        send_frame(16'hA5F3, 1'b1, 0);
        send_frame(16'hA5F3, 1'b1, 1);

        send_frame(16'h1248, 1'b0, 0);
        send_frame(N'($urandom), 1'b0, 0);

        send_bits(40);

        send_frame(N'($urandom), 1'b1, 0);
        send_bits(9);
        send_frame(N'($urandom), 1'b1, 0);
        send_frame(N'($urandom), 1'b1, 0);

        send_bits(N - 1);
        send_frame(N'($urandom), 1'b1, 0);

        send_frame(N'($urandom), 1'b1, 0);
        send_bits(6);
        do_reset(2);
        send_bits(5);
        send_frame(N'($urandom), 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                send_frame(N'($urandom), 1'b1, $urandom_range(0, 2));
            end else if (r < 85) begin
                send_frame(N'($urandom), 1'b0, $urandom_range(0, 2));
            end else if (r < 95) begin
                send_bits($urandom_range(1, N - 1));
                send_frame(N'($urandom), 1'b1, 0);
            end else begin
                send_bits($urandom_range(1, 20));
            end
        end

        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
